// File: rtl/global_ofm_store_unit_if.sv
// Bus bundle for global_ofm_store_unit: start/config, fused-block beat
// handshake, and the global BRAM write port.
interface global_ofm_store_unit_if #(
  parameter int DATA_W = 32,
  parameter int WORD_W = 128
);
  logic              start;
  logic [31:0]       base_addr_OFM;
  logic [31:0]       size_OFM;
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic [31:0]       wr_addr_global;
  logic [WORD_W-1:0] wr_data_global;
  logic              we_global;
  logic              busy;
  logic              done;

  // Side that requests stores and supplies beats
  modport master (
    output start, base_addr_OFM, size_OFM, in_valid, in_data,
    input  in_ready, wr_addr_global, wr_data_global, we_global, busy, done
  );

  // The store unit itself
  modport slave (
    input  start, base_addr_OFM, size_OFM, in_valid, in_data,
    output in_ready, wr_addr_global, wr_data_global, we_global, busy, done
  );
endinterface

// File: rtl/global_ofm_store_unit.sv
// global_ofm_store_unit: packs DATA_W beats from the fused block into
// WORD_W words and writes them to global BRAM starting at base_addr_OFM.
// Optional feature macro: OFM_PARTIAL_FLUSH_EN -- when defined, a trailing
// partial word is written with unfilled lanes zeroed; otherwise it is dropped.
module global_ofm_store_unit #(
  parameter int DATA_W = 32,
  parameter int WORD_W = 128
) (
  input  logic                     clk,
  input  logic                     reset_n,
  global_ofm_store_unit_if.slave   bus
);

  localparam int LANES = WORD_W / DATA_W;
  localparam int LW    = $clog2(LANES);

  typedef enum logic [1:0] {IDLE, PACK, WRITE_LAST, DONE} state_t;

  state_t            state;
  logic [31:0]       base_q;
  logic [31:0]       size_q;
  logic [31:0]       byte_cnt;
  logic [27:0]       word_idx;
  logic [LW-1:0]     lane;
  logic [WORD_W-1:0] pack;
  logic              fin;

  logic              accept;
  logic [31:0]       cnt_next;
  logic              last_beat;
  logic              lane_full;
  logic [31:0]       word_addr;
  logic [WORD_W-1:0] pack_next;

  assign accept    = bus.in_valid & bus.in_ready;
  assign cnt_next  = byte_cnt + 32'd4;
  assign last_beat = (cnt_next == size_q);
  assign lane_full = (lane == LW'(LANES - 1));
  assign word_addr = base_q + {word_idx, 4'b0000};

  // Pack register with the incoming beat dropped into the current lane
  always_comb begin
    pack_next = pack;
    for (int unsigned l = 0; l < LANES; l++) begin
      if (lane == LW'(l)) pack_next[l*DATA_W +: DATA_W] = bus.in_data;
    end
  end

  // Control FSM with registered outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state              <= IDLE;
      base_q             <= '0;
      size_q             <= '0;
      byte_cnt           <= '0;
      word_idx           <= '0;
      lane               <= '0;
      pack               <= '0;
      fin                <= 1'b0;
      bus.in_ready       <= 1'b0;
      bus.wr_addr_global <= '0;
      bus.wr_data_global <= '0;
      bus.we_global      <= 1'b0;
      bus.busy           <= 1'b0;
      bus.done           <= 1'b0;
    end else begin
      bus.we_global <= 1'b0;
      bus.done      <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            base_q   <= bus.base_addr_OFM;
            size_q   <= bus.size_OFM;
            byte_cnt <= '0;
            word_idx <= '0;
            lane     <= '0;
            pack     <= '0;
            fin      <= 1'b0;
            bus.busy <= 1'b1;
            if (bus.size_OFM == 32'd0) begin
              state    <= DONE;
              bus.done <= 1'b1;
            end else begin
              state        <= PACK;
              bus.in_ready <= 1'b1;
            end
          end
        end
        PACK: begin
          // fin marks the cycle in which the final full word is on the bus;
          // done follows it one cycle later
          if (fin) begin
            fin      <= 1'b0;
            state    <= DONE;
            bus.done <= 1'b1;
          end else if (accept) begin
            byte_cnt <= cnt_next;
            if (lane_full) begin
              bus.we_global      <= 1'b1;
              bus.wr_data_global <= pack_next;
              bus.wr_addr_global <= word_addr;
              word_idx           <= word_idx + 28'd1;
              lane               <= '0;
              pack               <= '0;
              if (last_beat) begin
                fin          <= 1'b1;
                bus.in_ready <= 1'b0;
              end
            end else begin
              lane <= lane + LW'(1);
              pack <= pack_next;
              if (last_beat) begin
                state        <= WRITE_LAST;
                bus.in_ready <= 1'b0;
`ifdef OFM_PARTIAL_FLUSH_EN
                // Flush word is registered on entry so its write pulse is
                // visible during WRITE_LAST; higher lanes are still zero
                bus.we_global      <= 1'b1;
                bus.wr_data_global <= pack_next;
                bus.wr_addr_global <= word_addr;
                word_idx           <= word_idx + 28'd1;
`endif
              end
            end
          end
        end
        WRITE_LAST: begin
          state    <= DONE;
          bus.done <= 1'b1;
        end
        DONE: begin
          state    <= IDLE;
          bus.busy <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_global_ofm_store_unit.sv
// Directed testbench for global_ofm_store_unit (honours OFM_PARTIAL_FLUSH_EN).
module tb_global_ofm_store_unit;

  logic clk;
  logic reset_n;
  int   cyc;
  int   n_cmp, n_err;

  global_ofm_store_unit_if #(.DATA_W(32), .WORD_W(128)) bus_if ();

  global_ofm_store_unit #(.DATA_W(32), .WORD_W(128)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Observed traffic, sampled on the falling edge
  logic [31:0]  wa_q[$];
  logic [127:0] wd_q[$];
  int           wc_q[$];
  int           done_cnt, done_cyc, hs_cnt, hs_cyc;

  always @(negedge clk) begin
    if (bus_if.we_global) begin
      wa_q.push_back(bus_if.wr_addr_global);
      wd_q.push_back(bus_if.wr_data_global);
      wc_q.push_back(cyc);
    end
    if (bus_if.done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (bus_if.in_valid && bus_if.in_ready) begin
      hs_cnt++;
      hs_cyc = cyc;
    end
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] qa(input int i);
    return (wa_q.size() > i) ? wa_q[i] : 32'hxxxxxxxx;
  endfunction
  function automatic logic [127:0] qd(input int i);
    return (wd_q.size() > i) ? wd_q[i] : {128{1'bx}};
  endfunction
  function automatic int qc(input int i);
    return (wc_q.size() > i) ? wc_q[i] : -100;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    wa_q.delete();
    wd_q.delete();
    wc_q.delete();
    done_cnt = 0;
    hs_cnt   = 0;
    done_cyc = -1;
    hs_cyc   = -1;
  endtask

  task automatic do_start(input logic [31:0] base, input logic [31:0] size);
    bus_if.start         = 1'b1;
    bus_if.base_addr_OFM = base;
    bus_if.size_OFM      = size;
    tick();
    bus_if.start = 1'b0;
  endtask

  task automatic send_beats(input int n, input logic [31:0] first, input bit gap);
    bit rdy, to;
    int b;
    to = 1'b0;
    for (int i = 0; i < n; i++) begin
      bus_if.in_valid = 1'b1;
      bus_if.in_data  = first + 32'(i);
      rdy = 1'b0;
      b   = 0;
      while (!rdy && b < 50) begin
        rdy = bus_if.in_ready;
        tick();
        b++;
      end
      if (!rdy) to = 1'b1;
      if (gap) begin
        bus_if.in_valid = 1'b0;
        bus_if.in_data  = 32'hDEADBEEF;
        tick();
      end
    end
    bus_if.in_valid = 1'b0;
    bus_if.in_data  = 32'hDEADBEEF;
    chk("hs_timeout", 128'(to), 128'(0));
  endtask

  task automatic wait_done();
    int d0, b;
    d0 = done_cnt;
    b  = 0;
    while (done_cnt == d0 && b < 50) begin
      tick();
      b++;
    end
    chk("done_seen", 128'(done_cnt > d0), 128'(1));
    tick();
  endtask

  int last_hs, st_cyc;

  initial begin
    n_cmp = 0; n_err = 0; cyc = 0;
    reset_n = 1'b0;
    bus_if.start = 1'b0; bus_if.base_addr_OFM = '0; bus_if.size_OFM = '0;
    bus_if.in_valid = 1'b0; bus_if.in_data = '0;
    clr();
    repeat (3) tick();
    chk("rst_in_ready", 128'(bus_if.in_ready), 128'(0));
    chk("rst_we", 128'(bus_if.we_global), 128'(0));
    chk("rst_busy", 128'(bus_if.busy), 128'(0));
    chk("rst_done", 128'(bus_if.done), 128'(0));
    chk("rst_addr", 128'(bus_if.wr_addr_global), 128'(0));
    chk("rst_data", bus_if.wr_data_global, 128'(0));
    reset_n = 1'b1;
    tick();

    // Two full words, back to back
    clr();
    do_start(32'h1000, 32'd32);
    chk("t1_busy", 128'(bus_if.busy), 128'(1));
    send_beats(8, 32'h01, 1'b0);
    wait_done();
    chk("t1_nwr", 128'(wa_q.size()), 128'(2));
    chk("t1_a0", 128'(qa(0)), 128'(32'h1000));
    chk("t1_d0", qd(0), 128'h00000004_00000003_00000002_00000001);
    chk("t1_a1", 128'(qa(1)), 128'(32'h1010));
    chk("t1_d1", qd(1), 128'h00000008_00000007_00000006_00000005);
    chk("t1_b2b", 128'(qc(1) - qc(0)), 128'(4));
    chk("t1_done_lat", 128'(done_cyc - qc(1)), 128'(1));
    chk("t1_ndone", 128'(done_cnt), 128'(1));
    chk("t1_idle", 128'(bus_if.busy), 128'(0));

    // One full word plus a two-beat tail
    clr();
    do_start(32'h2000, 32'd24);
    send_beats(6, 32'h11, 1'b0);
    last_hs = hs_cyc;
    wait_done();
    chk("t2_a0", 128'(qa(0)), 128'(32'h2000));
    chk("t2_d0", qd(0), 128'h00000014_00000013_00000012_00000011);
`ifdef OFM_PARTIAL_FLUSH_EN
    chk("t2_nwr", 128'(wa_q.size()), 128'(2));
    chk("t2_a1", 128'(qa(1)), 128'(32'h2010));
    chk("t2_d1", qd(1), 128'h00000000_00000000_00000016_00000015);
`else
    chk("t2_nwr", 128'(wa_q.size()), 128'(1));
`endif
    chk("t2_done_lat", 128'(done_cyc - last_hs), 128'(2));
    chk("t2_ndone", 128'(done_cnt), 128'(1));

    // in_valid toggling every cycle, garbage data while idle-valid
    clr();
    do_start(32'h3000, 32'd16);
    send_beats(4, 32'hA1, 1'b1);
    last_hs = hs_cyc;
    wait_done();
    chk("t3_nwr", 128'(wa_q.size()), 128'(1));
    chk("t3_a0", 128'(qa(0)), 128'(32'h3000));
    chk("t3_d0", qd(0), 128'h000000A4_000000A3_000000A2_000000A1);
    chk("t3_we_lat", 128'(qc(0) - last_hs), 128'(1));

    // start while busy is ignored
    clr();
    do_start(32'h4000, 32'd16);
    send_beats(2, 32'hD1, 1'b0);
    do_start(32'h9000, 32'd0);
    send_beats(2, 32'hD3, 1'b0);
    wait_done();
    chk("t4_nwr", 128'(wa_q.size()), 128'(1));
    chk("t4_a0", 128'(qa(0)), 128'(32'h4000));
    chk("t4_d0", qd(0), 128'h000000D4_000000D3_000000D2_000000D1);
    chk("t4_ndone", 128'(done_cnt), 128'(1));

    // size 0: done right after accept, no writes, offered beats not taken
    clr();
    bus_if.in_valid = 1'b1;
    bus_if.in_data  = 32'h55;
    do_start(32'h5000, 32'd0);
    st_cyc = cyc;
    repeat (4) tick();
    bus_if.in_valid = 1'b0;
    chk("t5_done_lat", 128'(done_cyc), 128'(st_cyc));
    chk("t5_ndone", 128'(done_cnt), 128'(1));
    chk("t5_nwr", 128'(wa_q.size()), 128'(0));
    chk("t5_nhs", 128'(hs_cnt), 128'(0));

    // Reset mid-word, then a clean restart
    clr();
    do_start(32'h6000, 32'd16);
    send_beats(2, 32'hB1, 1'b0);
    #2 reset_n = 1'b0;
    #1;
    chk("t6_async_busy", 128'(bus_if.busy), 128'(0));
    chk("t6_async_rdy", 128'(bus_if.in_ready), 128'(0));
    repeat (2) tick();
    reset_n = 1'b1;
    repeat (3) tick();
    chk("t6_nostale", 128'(wa_q.size()), 128'(0));
    do_start(32'h7000, 32'd16);
    send_beats(4, 32'hC1, 1'b0);
    wait_done();
    chk("t6_nwr", 128'(wa_q.size()), 128'(1));
    chk("t6_a0", 128'(qa(0)), 128'(32'h7000));
    chk("t6_d0", qd(0), 128'h000000C4_000000C3_000000C2_000000C1);

    // Address wrap at 2^32
    clr();
    do_start(32'hFFFFFFF0, 32'd32);
    send_beats(8, 32'h21, 1'b0);
    wait_done();
    chk("t7_nwr", 128'(wa_q.size()), 128'(2));
    chk("t7_a0", 128'(qa(0)), 128'(32'hFFFFFFF0));
    chk("t7_a1", 128'(qa(1)), 128'(32'h00000000));
    chk("t7_d1", qd(1), 128'h00000028_00000027_00000026_00000025);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
